pc_fetch_sequencer: RTL

Fetch-side controller that drives the program counter's command inputs (`inc`, `load`, `clear`, `offset`) and consumes its `address_out`/`flag` outputs. It clears the PC on start and reads instruction memory at the PC address. It presents each instruction to the core over a valid/ready handshake, then advances the PC by increment or relative branch. It also checks every PC update against an internally predicted address.

---
 rtl/pc_fetch_sequencer_if.sv | 33 +++
 rtl/pc_fetch_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Bundle of the PC command/status bus, the instruction memory port and the
// instruction handshake toward the core, as seen by the fetch sequencer.
interface pc_fetch_sequencer_if;
    logic [7:0]  pc_addr;
    logic [2:0]  pc_flag;
    logic        pc_inc;
    logic        pc_load;
    logic        pc_clear;
    logic [7:0]  pc_offset;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_req;
    logic [7:0]  branch_offset;

    modport master (
        input  pc_addr, pc_flag, imem_data, imem_valid,
               instr_ready, branch_req, branch_offset,
        output pc_inc, pc_load, pc_clear, pc_offset,
               imem_rd, imem_addr, instr, instr_valid
    );

    modport slave (
        output pc_addr, pc_flag, imem_data, imem_valid,
               instr_ready, branch_req, branch_offset,
        input  pc_inc, pc_load, pc_clear, pc_offset,
               imem_rd, imem_addr, instr, instr_valid
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: clears the PC, fetches at the PC address, hands each
// instruction to the core and advances the PC, cross-checking every update.
module pc_fetch_sequencer #(
    parameter int TIMEOUT = 7
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 halt,
    pc_fetch_sequencer_if.master bus,
    output logic                 busy,
    output logic                 pc_err,
    output logic [15:0]          retired
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT_MEM,
        S_ISSUE,
        S_CMD,
        S_WAIT_PC
    } state_t;

    state_t        state_reg;
    logic [7:0]    expect_reg;
    logic [7:0]    cur_reg;
    logic          halt_pend_reg;
    logic [CW-1:0] tmo_reg;

    logic          pc_inc_reg;
    logic          pc_load_reg;
    logic          pc_clear_reg;
    logic [7:0]    pc_offset_reg;
    logic          imem_rd_reg;
    logic [7:0]    imem_addr_reg;
    logic [15:0]   instr_reg;
    logic          instr_valid_reg;
    logic          busy_reg;
    logic          pc_err_reg;
    logic [15:0]   retired_reg;

    assign bus.pc_inc      = pc_inc_reg;
    assign bus.pc_load     = pc_load_reg;
    assign bus.pc_clear    = pc_clear_reg;
    assign bus.pc_offset   = pc_offset_reg;
    assign bus.imem_rd     = imem_rd_reg;
    assign bus.imem_addr   = imem_addr_reg;
    assign bus.instr       = instr_reg;
    assign bus.instr_valid = instr_valid_reg;
    assign busy            = busy_reg;
    assign pc_err          = pc_err_reg;
    assign retired         = retired_reg;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            expect_reg      <= 8'h00;
            cur_reg         <= 8'h00;
            halt_pend_reg   <= 1'b0;
            tmo_reg         <= '0;
            pc_inc_reg      <= 1'b0;
            pc_load_reg     <= 1'b0;
            pc_clear_reg    <= 1'b0;
            pc_offset_reg   <= 8'h00;
            imem_rd_reg     <= 1'b0;
            imem_addr_reg   <= 8'h00;
            instr_reg       <= 16'h0000;
            instr_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            pc_err_reg      <= 1'b0;
            retired_reg     <= 16'h0000;
        end else begin
            // A halt is only remembered while running; it is acted on at the
            // next point where the PC has settled.
            if (halt && state_reg != S_IDLE) begin
                halt_pend_reg <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start && !pc_err_reg) begin
                        state_reg     <= S_CLEAR;
                        retired_reg   <= 16'h0000;
                        halt_pend_reg <= 1'b0;
                        expect_reg    <= 8'h00;
                        pc_clear_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    pc_clear_reg <= 1'b0;
                    tmo_reg      <= '0;
                    state_reg    <= S_WAIT_PC;
                end

                S_WAIT_PC: begin
                    if (bus.pc_flag == 3'b000) begin
                        if (bus.pc_addr != expect_reg) begin
                            pc_err_reg <= 1'b1;
                            busy_reg   <= 1'b0;
                            state_reg  <= S_IDLE;
                        end else if (halt_pend_reg || halt) begin
                            busy_reg  <= 1'b0;
                            state_reg <= S_IDLE;
                        end else begin
                            imem_rd_reg   <= 1'b1;
                            imem_addr_reg <= bus.pc_addr;
                            cur_reg       <= bus.pc_addr;
                            state_reg     <= S_FETCH;
                        end
                    end else if (tmo_reg == CW'(TIMEOUT - 1)) begin
                        pc_err_reg <= 1'b1;
                        busy_reg   <= 1'b0;
                        state_reg  <= S_IDLE;
                    end else begin
                        tmo_reg <= tmo_reg + CW'(1);
                    end
                end

                S_FETCH: begin
                    imem_rd_reg <= 1'b0;
                    state_reg   <= S_WAIT_MEM;
                end

                S_WAIT_MEM: begin
                    if (bus.imem_valid) begin
                        instr_reg       <= bus.imem_data;
                        instr_valid_reg <= 1'b1;
                        state_reg       <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (bus.instr_ready) begin
                        retired_reg     <= retired_reg + 16'd1;
                        instr_valid_reg <= 1'b0;
                        state_reg       <= S_CMD;
                        // The PC's relative load lands one short of cur+offset.
                        if (bus.branch_req) begin
                            pc_offset_reg <= bus.branch_offset;
                            expect_reg    <= cur_reg + bus.branch_offset - 8'd1;
                            pc_load_reg   <= 1'b1;
                        end else begin
                            expect_reg <= cur_reg + 8'd1;
                            pc_inc_reg <= 1'b1;
                        end
                    end
                end

                S_CMD: begin
                    pc_inc_reg  <= 1'b0;
                    pc_load_reg <= 1'b0;
                    tmo_reg     <= '0;
                    state_reg   <= S_WAIT_PC;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule
